// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: accepts one rectangle command and streams one clipped
// pixel write per clock to vga_adapter. Optional macro RECT_FILL_ABORT_EN adds an abort input.
module rect_fill_engine #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int W_W      = 5,
    parameter int H_W      = 4
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [7:0]     req_x,
    input  logic [6:0]     req_y,
    input  logic [W_W-1:0] req_w,
    input  logic [H_W-1:0] req_h,
    input  logic [2:0]     req_colour,
`ifdef RECT_FILL_ABORT_EN
    input  logic           abort,
`endif
    output logic [7:0]     x_out,
    output logic [6:0]     y_out,
    output logic [2:0]     colour_out,
    output logic           plot,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [W_W-1:0] W_ONE     = W_W'(1);
    localparam logic [H_W-1:0] H_ONE     = H_W'(1);
    localparam logic [8:0]     SCREEN_W9 = 9'(SCREEN_W);
    localparam logic [7:0]     SCREEN_H8 = 8'(SCREEN_H);

    state_t         state;
    logic [7:0]     base_x;
    logic [6:0]     base_y;
    logic [W_W-1:0] w_q;
    logic [H_W-1:0] h_q;
    logic [2:0]     colour_q;
    logic [W_W-1:0] cx;
    logic [H_W-1:0] cy;

    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       last_col;
    logic       last_row;
    logic       abort_now;

    // Sums are one bit wider than the screen coordinates so off-screen pixels clip instead of wrapping.
    assign sum_x    = {1'b0, base_x} + 9'(cx);
    assign sum_y    = {1'b0, base_y} + 8'(cy);
    assign last_col = (cx == w_q - W_ONE);
    assign last_row = (cy == h_q - H_ONE);

`ifdef RECT_FILL_ABORT_EN
    assign abort_now = abort;
`else
    assign abort_now = 1'b0;
`endif

    // NOTE: reset is synchronous (sampled on clk), and all state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            base_x   <= '0;
            base_y   <= '0;
            w_q      <= '0;
            h_q      <= '0;
            colour_q <= '0;
            cx       <= '0;
            cy       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base_x   <= req_x;
                        base_y   <= req_y;
                        w_q      <= req_w;
                        h_q      <= req_h;
                        colour_q <= req_colour;
                        cx       <= '0;
                        cy       <= '0;
                        state    <= (req_w == '0 || req_h == '0) ? DONE : FILL;
                    end
                end
                FILL: begin
                    if (abort_now || (last_col && last_row)) begin
                        state <= DONE;
                    end else if (last_col) begin
                        cx <= '0;
                        cy <= cy + H_ONE;
                    end else begin
                        cx <= cx + W_ONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode only registered state, except abort which must mask the current pixel.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        req_ready  = (state == IDLE);
        busy       = (state != IDLE);
        done       = (state == DONE);
        x_out      = '0;
        y_out      = '0;
        colour_out = '0;
        plot       = 1'b0;
        if (state == FILL) begin
            x_out      = sum_x[7:0];
            y_out      = sum_y[6:0];
            colour_out = colour_q;
            plot       = (sum_x < SCREEN_W9) && (sum_y < SCREEN_H8) && !abort_now;
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed self-checking bench for rect_fill_engine; covers the abort input when
// RECT_FILL_ABORT_EN is defined.
module tb_rect_fill_engine;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [4:0] req_w;
    logic [3:0] req_h;
    logic [2:0] req_colour;
    logic       abort;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rect_fill_engine dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_colour (req_colour),
`ifdef RECT_FILL_ABORT_EN
        .abort      (abort),
`endif
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    // Present a command at a falling edge; it is accepted on the following rising edge.
    task automatic drive_cmd(input int x, input int y, input int w, input int h, input int c);
        req_x      = 8'(x);
        req_y      = 7'(y);
        req_w      = 5'(w);
        req_h      = 4'(h);
        req_colour = 3'(c);
        req_valid  = 1'b1;
    endtask

    task automatic scramble_req();
        req_valid  = 1'b0;
        req_x      = 8'd99;
        req_y      = 7'd77;
        req_w      = 5'd3;
        req_h      = 4'd1;
        req_colour = 3'd7;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req_valid = 1'b0;
        abort = 1'b0;
        req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1 ||
            x_out !== 8'd0 || y_out !== 7'd0 || colour_out !== 3'd0) begin
            fails++;
            $display("FAIL reset_state: plot=%b busy=%b done=%b ready=%b xy=(%0d,%0d) c=%0d, want 0 0 0 1 (0,0) 0",
                     plot, busy, done, req_ready, x_out, y_out, colour_out);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_fill();
        int ex, ey;
        drive_cmd(16, 8, 16, 4, 2);
        @(negedge clk);
        scramble_req();
        for (int i = 0; i < 64; i++) begin
            ex = 16 + (i % 16);
            ey = 8 + (i / 16);
            tests++;
            if (plot !== 1'b1 || x_out !== 8'(ex) || y_out !== 7'(ey) || colour_out !== 3'b010 ||
                req_ready !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL basic_pixel%0d: plot=%b (%0d,%0d) c=%0d ready=%b done=%b, want plot=1 (%0d,%0d) c=2 ready=0 done=0",
                         i + 1, plot, x_out, y_out, colour_out, req_ready, done, ex, ey);
            end
            @(negedge clk);
        end
        tests++;
        if (done !== 1'b1 || plot !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_done: done=%b plot=%b ready=%b busy=%b, want 1 0 0 1", done, plot, req_ready, busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || x_out !== 8'd0 || colour_out !== 3'd0) begin
            fails++;
            $display("FAIL basic_idle: done=%b ready=%b busy=%b x=%0d c=%0d, want 0 1 0 0 0",
                     done, req_ready, busy, x_out, colour_out);
        end
    endtask

    task automatic test_clip();
        int ex, ey, plots;
        logic ep;
        plots = 0;
        drive_cmd(150, 118, 16, 4, 5);
        @(negedge clk);
        scramble_req();
        for (int i = 0; i < 64; i++) begin
            ex = 150 + (i % 16);
            ey = 118 + (i / 16);
            ep = (ex < 160) && (ey < 120);
            if (plot === 1'b1) plots++;
            tests++;
            if (plot !== ep || x_out !== 8'(ex) || y_out !== 7'(ey) || done !== 1'b0) begin
                fails++;
                $display("FAIL clip_pixel%0d: plot=%b (%0d,%0d) done=%b, want plot=%b (%0d,%0d) done=0",
                         i + 1, plot, x_out, y_out, done, ep, ex, ey);
            end
            @(negedge clk);
        end
        tests++;
        if (plots != 20) begin
            fails++;
            $display("FAIL clip_count: %0d plots, want 20", plots);
        end
        tests++;
        if (done !== 1'b1 || plot !== 1'b0) begin
            fails++;
            $display("FAIL clip_done: done=%b plot=%b, want 1 0", done, plot);
        end
        @(negedge clk);
    endtask

    task automatic test_empty();
        drive_cmd(10, 10, 0, 4, 1);
        @(negedge clk);
        scramble_req();
        tests++;
        if (done !== 1'b1 || plot !== 1'b0 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL empty_done: done=%b plot=%b ready=%b, want 1 0 0", done, plot, req_ready);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || plot !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL empty_idle: done=%b plot=%b ready=%b, want 0 0 1", done, plot, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int exa[4] = '{0, 1, 0, 1};
        int eya[4] = '{0, 0, 1, 1};
        drive_cmd(0, 0, 2, 2, 1);
        @(negedge clk);
        drive_cmd(5, 5, 1, 1, 4);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (plot !== 1'b1 || x_out !== 8'(exa[i]) || y_out !== 7'(eya[i]) || colour_out !== 3'd1 ||
                req_ready !== 1'b0) begin
                fails++;
                $display("FAIL b2b_first%0d: plot=%b (%0d,%0d) c=%0d ready=%b, want plot=1 (%0d,%0d) c=1 ready=0",
                         i + 1, plot, x_out, y_out, colour_out, req_ready, exa[i], eya[i]);
            end
            @(negedge clk);
        end
        tests++;
        if (done !== 1'b1 || req_ready !== 1'b0 || plot !== 1'b0) begin
            fails++;
            $display("FAIL b2b_done1: done=%b ready=%b plot=%b, want 1 0 0", done, req_ready, plot);
        end
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || plot !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept2: ready=%b plot=%b, want 1 0", req_ready, plot);
        end
        @(negedge clk);
        scramble_req();
        tests++;
        if (plot !== 1'b1 || x_out !== 8'd5 || y_out !== 7'd5 || colour_out !== 3'd4) begin
            fails++;
            $display("FAIL b2b_second: plot=%b (%0d,%0d) c=%0d, want plot=1 (5,5) c=4", plot, x_out, y_out, colour_out);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || plot !== 1'b0) begin
            fails++;
            $display("FAIL b2b_done2: done=%b plot=%b, want 1 0", done, plot);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fill();
        int plots;
        plots = 0;
        drive_cmd(16, 8, 16, 4, 6);
        @(negedge clk);
        scramble_req();
        for (int i = 0; i < 10; i++) begin
            if (plot === 1'b1) plots++;
            if (i < 9) @(negedge clk);
        end
        tests++;
        if (plots != 10) begin
            fails++;
            $display("FAIL midreset_plots: %0d plots before reset, want 10", plots);
        end
        resetn = 1'b0;
        @(negedge clk);
        tests++;
        if (plot !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0 || x_out !== 8'd0) begin
            fails++;
            $display("FAIL midreset_state: plot=%b busy=%b ready=%b done=%b x=%0d, want 0 0 1 0 0",
                     plot, busy, req_ready, done, x_out);
        end
        resetn = 1'b1;
        @(negedge clk);
        tests++;
        if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_after: plot=%b done=%b busy=%b, want 0 0 0", plot, done, busy);
        end
    endtask

`ifdef RECT_FILL_ABORT_EN
    task automatic test_abort();
        int plots;
        plots = 0;
        drive_cmd(16, 8, 16, 4, 3);
        @(negedge clk);
        scramble_req();
        for (int i = 0; i < 9; i++) begin
            if (plot === 1'b1) plots++;
            @(negedge clk);
        end
        abort = 1'b1;
        #1;
        tests++;
        if (plots != 9 || plot !== 1'b0) begin
            fails++;
            $display("FAIL abort_cycle: %0d plots, plot=%b on abort cycle, want 9 plots and plot=0", plots, plot);
        end
        @(negedge clk);
        abort = 1'b0;
        tests++;
        if (done !== 1'b1 || plot !== 1'b0) begin
            fails++;
            $display("FAIL abort_done: done=%b plot=%b, want 1 0", done, plot);
        end
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: ready=%b done=%b, want 1 0", req_ready, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_fill();
        test_clip();
        test_empty();
        test_back_to_back();
        test_reset_mid_fill();
`ifdef RECT_FILL_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
